fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares one fifo_param instance (push side) between NREQ requesters and gates the consumer pop.
- Keeps a shadow occupancy counter that mirrors the FIFO count, so it never pushes into a full FIFO or pops an empty one.
- As a result, the FIFO never sees push and pop in the same cycle while it is full or empty.
- Sits between the producer agents and the FIFO; the consumer connects through it.

Parameters:
- WIDTH, 64, data width; must match the FIFO WIDTH.
- DEPTH, 4, FIFO pointer/count width; must match the FIFO DEPTH. Usable capacity CAP = 2^DEPTH - 1.
- NREQ, 4, number of requesters; legal range 2..16. PW = $clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NREQ  bit i = requester i has a word to write; held until granted.
- req_data  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot, combinational; bit i = requester i word accepted this cycle.
- fifo_push  out  1  to FIFO push.
- fifo_data  out  WIDTH  to FIFO data_in.
- fifo_pop  out  1  to FIFO pop.
- fifo_full  in  1  from FIFO, used for consistency checking only.
- fifo_empty  in  1  from FIFO, used for consistency checking only.
- cons_pop  in  1  consumer read request.
- cons_valid  out  1  FIFO holds at least one word (occ != 0).
- occupancy  out  DEPTH  shadow count occ.
- sync_err  out  1  sticky mismatch flag.

Behaviour:
- State registers:
  - stage_valid, stage_data[WIDTH]: one-entry holding stage.
  - rr_ptr[PW]: next requester with highest priority.
  - occ[DEPTH]: shadow occupancy.
  - sync_err.
- Reset (rst=0, asynchronous): all state cleared to 0. While rst=0: gnt=0, fifo_push=0, fifo_pop=0, cons_valid=0, occupancy=0, sync_err=0. The FIFO is reset together with this block.
- fifo_push = stage_valid && (occ != CAP). fifo_data = stage_data. Both driven from registers only.
- fifo_pop = cons_pop && (occ != 0). A pop with occ=0 is ignored silently.
- load_ok = !stage_valid || fifo_push. A new word can be accepted in the same cycle the stage drains.
- Arbitration, when load_ok:
  - Scan req starting at index rr_ptr, wrapping modulo NREQ. The first set bit i wins.
  - gnt[i]=1 in that cycle. At the clock edge: stage_data <= req_data[i], stage_valid <= 1, rr_ptr <= (i+1) mod NREQ.
- No winner, or !load_ok: gnt=0, rr_ptr unchanged. stage_valid <= stage_valid && !fifo_push.
- Latency: a grant in cycle T gives fifo_push in T+1 if occ != CAP. Back-to-back grants sustain 1 word/cycle.
- Fairness: every requester holding req is granted within NREQ accepted words.
- occ update:
  - +1 on push-only.
  - -1 on pop-only.
  - Unchanged on push and pop together. This is safe because both are only issued when 0 < occ < CAP, so the FIFO count also stays unchanged.
  - Unchanged when neither is issued.
- Full boundary: at occ = CAP the stage holds its word, with at most one word stalled. gnt stays 0 while stage_valid=1. A pop frees a slot; fifo_push asserts the next cycle.
- Empty boundary: cons_pop with occ=0 produces no fifo_pop. A word pushed in cycle T is poppable from T+1 (cons_valid=1).
- sync_err: set at a clock edge when (fifo_full != (occ == CAP)) or (fifo_empty != (occ == 0)). It clears only on reset.
- Reset mid-operation: the staged word and all in-flight state are discarded. rr_ptr returns to 0.
- The requester must hold req and req_data stable until its gnt. Dropping req before gnt is legal and the word is simply not taken.

Test Plan (WIDTH=8, DEPTH=2, so CAP=3; NREQ=4):
- Reset and idle: rst=0 then released, req=0 -> all outputs 0, occupancy=0, sync_err=0 for 10 cycles.
- Round-robin: req=4'b1111 held, cons_pop=1 continuously, distinct data per requester -> gnt sequence 0001, 0010, 0100, 1000, 0001. FIFO output order is req0..req3 data, with no missing or duplicate words.
- Fill to full:
  - req0 only with data 0x11, 0x22, 0x33, 0x44, cons_pop=0 -> occupancy 1, 2, 3.
  - 0x44 stalls in the stage, fifo_push=0, gnt=0. fifo_full=1 and sync_err stays 0.
  - Then one cons_pop -> 0x11 read, 0x44 pushed the next cycle, occupancy returns to 3.
- Simultaneous push and pop at occ=2: a steady grant stream plus cons_pop=1 -> occupancy stays 2 each cycle, and the FIFO count matches.
- Pop when empty: cons_pop=1 with occ=0 -> fifo_pop=0, fifo_empty stays 1, sync_err=0.
- Mid-operation reset: rst=0 asserted for 1 cycle while occ=2 and the stage is full -> all outputs 0 asynchronously. After release, req2 is granted first from rr_ptr=0 when req=4'b0100.

Source files
------------

// File: rtl/fifo_push_arbiter_if.sv
// Producer/consumer/FIFO-side signals of fifo_push_arbiter, bundled as one port.
// The parameters must match the arbiter instance that takes the slave modport.
interface fifo_push_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_push;
  logic [WIDTH-1:0]      fifo_data;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  cons_pop;
  logic                  cons_valid;
  logic [DEPTH-1:0]      occupancy;
  logic                  sync_err;

  modport slave (
    input  req, req_data, fifo_full, fifo_empty, cons_pop,
    output gnt, fifo_push, fifo_data, fifo_pop, cons_valid, occupancy, sync_err
  );

  modport master (
    output req, req_data, fifo_full, fifo_empty, cons_pop,
    input  gnt, fifo_push, fifo_data, fifo_pop, cons_valid, occupancy, sync_err
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of a shared FIFO: one holding stage, a
// shadow occupancy counter that gates push/pop, and a sticky FIFO-sync check.
module fifo_push_arbiter #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int NREQ  = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_push_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [DEPTH-1:0] CAP = '1;

  logic                         stage_valid_q, stage_valid_d;
  logic [WIDTH-1:0]             stage_data_q, stage_data_d;
  logic [PW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [DEPTH-1:0]             occ_q, occ_d;
  logic                         sync_err_q, sync_err_d;

  logic [NREQ-1:0][WIDTH-1:0]   req_vec;
  logic                         push, pop, load_ok, grant;
  logic                         win_vld;
  logic [PW-1:0]                win_idx, idx;
  logic [PW:0]                  sum;
  logic [NREQ-1:0]              gnt;

  assign req_vec = bus.req_data;

  // Rotating-priority scan: first set request at or after rr_ptr, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    push    = stage_valid_q && (occ_q != CAP);
    pop     = bus.cons_pop && (occ_q != '0);
    load_ok = !stage_valid_q || push;
    // rst gates the grant so nothing is acknowledged while the block is held in reset
    grant   = rst && load_ok && win_vld;

    gnt = '0;
    if (grant) gnt[win_idx] = 1'b1;

    stage_valid_d = grant ? 1'b1 : (stage_valid_q && !push);
    stage_data_d  = grant ? req_vec[win_idx] : stage_data_q;

    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;

    // push and pop together only happen with 0 < occ < CAP, so the count holds
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    sync_err_d = sync_err_q
               | (bus.fifo_full  != (occ_q == CAP))
               | (bus.fifo_empty != (occ_q == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      rr_ptr_q      <= '0;
      occ_q         <= '0;
      sync_err_q    <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      rr_ptr_q      <= rr_ptr_d;
      occ_q         <= occ_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign bus.gnt        = gnt;
  assign bus.fifo_push  = push;
  assign bus.fifo_data  = stage_data_q;
  assign bus.fifo_pop   = pop;
  assign bus.cons_valid = (occ_q != '0);
  assign bus.occupancy  = occ_q;
  assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter (WIDTH=8, DEPTH=2 -> CAP=3, NREQ=4)
// with a behavioural 3-entry FIFO on the push/pop side.
module tb_fifo_push_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  fifo_push_arbiter_if #(.WIDTH(8), .DEPTH(2), .NREQ(4)) bus ();

  fifo_push_arbiter #(.WIDTH(8), .DEPTH(2), .NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // FIFO model: 3 usable entries, popped words logged for order checks
  logic [7:0] fq[$];
  logic [7:0] popped[$];
  int         fcnt = 0;
  logic       bad_empty = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      fcnt <= 0;
    end else begin
      if (bus.fifo_pop && fq.size() > 0) popped.push_back(fq.pop_front());
      if (bus.fifo_push && fq.size() < 3) fq.push_back(bus.fifo_data);
      fcnt <= fq.size();
    end
  end

  assign bus.fifo_full  = (fcnt == 3);
  assign bus.fifo_empty = (fcnt == 0) ^ bad_empty;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {gnt[3:0], fifo_push, fifo_pop, cons_valid, occupancy[1:0], sync_err}
  function automatic logic [31:0] outs();
    return {22'd0, bus.gnt, bus.fifo_push, bus.fifo_pop, bus.cons_valid,
            bus.occupancy, bus.sync_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_ord [5] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
  logic [7:0] fill_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] sim_ord [8] = '{8'h22, 8'h33, 8'h44, 8'h60, 8'h61, 8'h62, 8'h63, 8'h64};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.req_data = 32'h0;
    bus.cons_pop = 1'b1;

    // reset held with requests pending: everything quiet
    repeat (2) tick();
    chk("rst_outs", outs(), 32'h0);

    bus.req = 4'b0000;
    bus.cons_pop = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("idle_outs", outs(), 32'h0);
      tick();
    end

    // round robin, all four requesting, consumer always popping
    popped.delete();
    bus.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.req = 4'b1111;
    bus.cons_pop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_gnt", {28'd0, bus.gnt}, {28'd0, rr_exp[k]});
      tick();
    end
    bus.req = 4'b0000;
    repeat (6) tick();
    chk("rr_occ", {30'd0, bus.occupancy}, 32'd0);
    chk("rr_cnt", popped.size(), 32'd5);
    for (int k = 0; k < 5 && k < popped.size(); k++)
      chk("rr_order", {24'd0, popped[k]}, {24'd0, rr_ord[k]});

    // fill to full from requester 0
    popped.delete();
    bus.cons_pop = 1'b0;
    bus.req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      bus.req_data = {24'd0, fill_v[k]};
      #1;
      chk("fill_gnt", {28'd0, bus.gnt}, 32'b0001);
      chk("fill_occ", {30'd0, bus.occupancy}, (k == 0) ? 32'd0 : 32'(k - 1));
      tick();
    end
    bus.req_data = 32'h55;
    #1;
    chk("full_outs", outs(), {22'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0});
    chk("full_data", {24'd0, bus.fifo_data}, 32'h44);
    chk("full_flag", {31'd0, bus.fifo_full}, 32'd1);
    tick();
    bus.req = 4'b0000;
    bus.cons_pop = 1'b1;
    #1 chk("full_pop", outs(), {22'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0});
    tick();
    bus.cons_pop = 1'b0;
    #1 chk("full_refill", outs(), {22'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0});
    chk("refill_data", {24'd0, bus.fifo_data}, 32'h44);
    tick();
    chk("refull_occ", {30'd0, bus.occupancy}, 32'd3);
    chk("refull_push", {31'd0, bus.fifo_push}, 32'd0);
    chk("full_popcnt", popped.size(), 32'd1);
    if (popped.size() > 0) chk("full_popval", {24'd0, popped[0]}, 32'h11);

    // simultaneous push and pop at occ=2
    popped.delete();
    bus.req = 4'b0001;
    bus.req_data = 32'h60;
    bus.cons_pop = 1'b1;
    #1 chk("sim_start", outs(), {22'd0, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0});
    tick();
    for (int k = 1; k < 5; k++) begin
      bus.req_data = 32'h60 + 32'(k);
      #1;
      chk("sim_outs", outs(), {22'd0, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0});
      chk("sim_fcnt", fcnt, 32'd2);
      tick();
    end
    bus.req = 4'b0000;
    repeat (6) tick();
    chk("sim_occ", {30'd0, bus.occupancy}, 32'd0);
    chk("sim_cnt", popped.size(), 32'd8);
    for (int k = 0; k < 8 && k < popped.size(); k++)
      chk("sim_order", {24'd0, popped[k]}, {24'd0, sim_ord[k]});

    // pop while empty is ignored
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("empty_outs", outs(), 32'h0);
      chk("empty_flag", {31'd0, bus.fifo_empty}, 32'd1);
      tick();
    end

    // build occ=2 with a staged word, then reset mid-operation
    bus.cons_pop = 1'b0;
    bus.req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      bus.req_data = 32'h70 + 32'(k);
      tick();
    end
    bus.req = 4'b0000;
    #1 chk("pre_rst", outs(), {22'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0});
    rst = 1'b0;
    bus.req = 4'b0100;
    bus.cons_pop = 1'b1;
    #1 chk("mid_rst", outs(), 32'h0);
    tick();
    rst = 1'b1;
    bus.cons_pop = 1'b0;
    bus.req_data = {8'h83, 8'h82, 8'h81, 8'h80};
    #1 chk("post_rst", outs(), {22'd0, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0});
    tick();
    bus.req = 4'b0000;
    #1 chk("post_push", {31'd0, bus.fifo_push}, 32'd1);
    chk("post_data", {24'd0, bus.fifo_data}, 32'h82);
    tick();

    // second reset with rr_ptr=3 beforehand: req 1001 must pick req0
    rst = 1'b0;
    #1 tick();
    rst = 1'b1;
    bus.req = 4'b1001;
    #1 chk("rr_reset", {28'd0, bus.gnt}, 32'b0001);
    tick();
    bus.req = 4'b0000;
    bus.cons_pop = 1'b1;
    repeat (4) tick();
    chk("drain_occ", {30'd0, bus.occupancy}, 32'd0);

    // sync_err: corrupt fifo_empty for one edge, flag must stick until reset
    bus.cons_pop = 1'b0;
    chk("sync_pre", {31'd0, bus.sync_err}, 32'd0);
    bad_empty = 1'b1;
    tick();
    bad_empty = 1'b0;
    #1 chk("sync_set", {31'd0, bus.sync_err}, 32'd1);
    tick();
    chk("sync_hold", {31'd0, bus.sync_err}, 32'd1);
    rst = 1'b0;
    #1 chk("sync_clr", {31'd0, bus.sync_err}, 32'd0);
    tick();
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
